// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b,
    input  diff, borrow_out, ovf, busy, done
  );

  modport slave (
    input  start, a, b,
    output diff, borrow_out, ovf, busy, done
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor cell time-shared over WIDTH bits, LSB first.
//   state  | meaning
//   IDLE   | waiting for start; results of the last operation held
//   SHIFT  | one bit per edge, WIDTH edges
//   DONE   | one-cycle done pulse, results valid
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  serial_sub_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] ra_q, rb_q, rd_q;
  logic             bin_q;
  logic [CW-1:0]    cnt_q;
  logic             a_msb_q, b_msb_q;
  logic             d_bit, bout;
  logic             busy_c, done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      SHIFT:   busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  assign d_bit = ra_q[0] ^ rb_q[0] ^ bin_q;
  assign bout  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bin_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      bin_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      ra_q    <= bus.a;
      rb_q    <= bus.b;
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
      bin_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      ra_q  <= ra_q >> 1;
      rb_q  <= rb_q >> 1;
      rd_q  <= {d_bit, rd_q[WIDTH-1:1]};
      bin_q <= bout;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Overflow only possible when operand signs differ and the result sign departs from a.
  assign bus.diff       = rd_q;
  assign bus.borrow_out = bin_q;
  assign bus.ovf        = (a_msb_q != b_msb_q) & (rd_q[WIDTH-1] != a_msb_q);
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at WIDTH 2, 8 and 16.
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(2))  bus2 ();
  serial_sub_if #(.WIDTH(8))  bus8 ();
  serial_sub_if #(.WIDTH(16)) bus16 ();

  serial_sub #(.WIDTH(2))  u2  (.clk(clk), .rst(rst), .bus(bus2));
  serial_sub #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: {borrow, ovf, diff} from integer arithmetic.
  function automatic logic [17:0] model(input int w, input int a, input int b);
    int d, sa, sb, sd;
    logic bo, ov;
    d  = (a - b) & ((1 << w) - 1);
    bo = (a < b);
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sd = sa - sb;
    ov = (sd > (1 << (w - 1)) - 1) || (sd < -(1 << (w - 1)));
    return {bo, ov, d[15:0]};
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int busy_cyc, output logic got);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    busy_cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus8.done) begin got = 1'b1; break; end
      if (bus8.busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic chk_res8(input string tag, input logic got, input logic [7:0] d,
                          input logic bo, input logic ov);
    chk({tag, "_done"}, {31'b0, got}, 32'd1);
    chk({tag, "_diff"}, {24'b0, bus8.diff}, {24'b0, d});
    chk({tag, "_borrow"}, {31'b0, bus8.borrow_out}, {31'b0, bo});
    chk({tag, "_ovf"}, {31'b0, bus8.ovf}, {31'b0, ov});
    chk({tag, "_busy_with_done"}, {31'b0, bus8.busy}, 32'd0);
  endtask

  initial begin
    int          bc, bad, k_acc, k_done, last_t;
    logic        got, prev_busy, g2, g8, g16;
    logic [7:0]  pa [3];
    logic [7:0]  pb [3];
    logic [17:0] r2, r8, r16, e2, e8, e16;
    int          a2, b2, a8, b8, a16, b16;

    bus2.start = 0;  bus2.a = '0;  bus2.b = '0;
    bus8.start = 0;  bus8.a = '0;  bus8.b = '0;
    bus16.start = 0; bus16.a = '0; bus16.b = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {19'b0, bus8.diff, bus8.borrow_out, bus8.ovf, bus8.busy, bus8.done}, 32'd0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus8.busy || bus8.done) bad++;
    end
    chk("idle_no_activity", bad, 0);

    // Basic op with hold afterwards
    op8(8'h5A, 8'h3C, bc, got);
    chk("basic_busy_cycles", bc, 8);
    chk_res8("basic", got, 8'h1E, 1'b0, 1'b0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus8.diff !== 8'h1E || bus8.borrow_out !== 1'b0 || bus8.ovf !== 1'b0 || bus8.done) bad++;
    end
    chk("basic_hold", bad, 0);

    // Boundaries
    op8(8'h00, 8'h01, bc, got);
    chk_res8("zero_minus_one", got, 8'hFF, 1'b1, 1'b0);
    op8(8'h80, 8'h01, bc, got);
    chk_res8("min_minus_one", got, 8'h7F, 1'b0, 1'b1);
    op8(8'hFF, 8'hFF, bc, got);
    chk_res8("ff_minus_ff", got, 8'h00, 1'b0, 1'b0);

    // Start while busy is ignored
    @(negedge clk);
    bus8.a = 8'h10; bus8.b = 8'h01; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus8.done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk_res8("start_while_busy", got, 8'h0F, 1'b0, 1'b0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.busy || bus8.done) bad++;
    end
    chk("start_while_busy_not_queued", bad, 0);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus8.a = 8'h77; bus8.b = 8'h11; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("midop_reset_outputs",
           {19'b0, bus8.diff, bus8.borrow_out, bus8.ovf, bus8.busy, bus8.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.busy || bus8.done) bad++;
    end
    chk("midop_reset_no_done", bad, 0);
    op8(8'h03, 8'h05, bc, got);
    chk_res8("after_reset", got, 8'hFE, 1'b1, 1'b0);

    // Back-to-back with start held high
    pa[0] = 8'h5A; pb[0] = 8'h3C;
    pa[1] = 8'h01; pb[1] = 8'h02;
    pa[2] = 8'h7F; pb[2] = 8'hFF;
    @(negedge clk);
    bus8.a = pa[0]; bus8.b = pb[0]; bus8.start = 1'b1;
    prev_busy = 1'b0; k_acc = 0; k_done = 0; last_t = 0;
    for (int t = 0; t < 80 && k_done < 3; t++) begin
      @(negedge clk);
      if (bus8.busy && !prev_busy) begin
        k_acc++;
        if (k_acc < 3) begin bus8.a = pa[k_acc]; bus8.b = pb[k_acc]; end
        else bus8.start = 1'b0;
      end
      prev_busy = bus8.busy;
      if (bus8.done) begin
        e8 = model(8, int'(pa[k_done]), int'(pb[k_done]));
        chk($sformatf("b2b_result%0d", k_done),
            {14'b0, bus8.borrow_out, bus8.ovf, 8'b0, bus8.diff}, {14'b0, e8});
        if (k_done > 0) chk($sformatf("b2b_spacing%0d", k_done), t - last_t, 10);
        last_t = t;
        k_done++;
      end
    end
    bus8.start = 1'b0;
    chk("b2b_done_count", k_done, 3);
    repeat (12) @(negedge clk);

    // Random sweep, three widths in lockstep
    for (int i = 0; i < 1000; i++) begin
      a2  = int'($urandom_range(0, 3));     b2  = int'($urandom_range(0, 3));
      a8  = int'($urandom_range(0, 255));   b8  = int'($urandom_range(0, 255));
      a16 = int'($urandom_range(0, 65535)); b16 = int'($urandom_range(0, 65535));
      @(negedge clk);
      bus2.a  = 2'(a2);   bus2.b  = 2'(b2);   bus2.start  = 1'b1;
      bus8.a  = 8'(a8);   bus8.b  = 8'(b8);   bus8.start  = 1'b1;
      bus16.a = 16'(a16); bus16.b = 16'(b16); bus16.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0; bus8.start = 1'b0; bus16.start = 1'b0;
      g2 = 1'b0; g8 = 1'b0; g16 = 1'b0;
      r2 = '0; r8 = '0; r16 = '0;
      for (int k = 0; k < 24 && !(g2 && g8 && g16); k++) begin
        if (bus2.done && !g2)   begin g2 = 1'b1;  r2  = {bus2.borrow_out, bus2.ovf, 14'b0, bus2.diff}; end
        if (bus8.done && !g8)   begin g8 = 1'b1;  r8  = {bus8.borrow_out, bus8.ovf, 8'b0, bus8.diff}; end
        if (bus16.done && !g16) begin g16 = 1'b1; r16 = {bus16.borrow_out, bus16.ovf, bus16.diff}; end
        @(negedge clk);
      end
      e2 = model(2, a2, b2); e8 = model(8, a8, b8); e16 = model(16, a16, b16);
      chk($sformatf("rand_w2_%0d", i),  {13'b0, g2, r2},   {13'b0, 1'b1, e2});
      chk($sformatf("rand_w8_%0d", i),  {13'b0, g8, r8},   {13'b0, 1'b1, e8});
      chk($sformatf("rand_w16_%0d", i), {13'b0, g16, r16}, {13'b0, 1'b1, e16});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
